mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_if.sv | 32 +++
 rtl/mem_wb_stage.sv | 112 +++++++++++
 tb/tb_mem_wb_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_if.sv
// MEM->WB stage bus: MEM-stage instruction fields in, WB-stage results out.
interface mem_wb_if;
  logic        valid_M;
  logic        memrd_M;
  logic        memwr_M;
  logic        regwrite_M;
  logic [4:0]  rd_M;
  logic [2:0]  wbsrcm;
  logic [31:0] ALUOut_M;
  logic [31:0] pc4_M;
  logic [31:0] readdata_M;
  logic        countdone;
  logic        stall_M;
  logic        valid_W;
  logic        regwrite_W;
  logic [4:0]  rd_W;
  logic [31:0] result_W;
  logic        misalign_W;
  logic        mem_timeout;

  modport master (
    output valid_M, memrd_M, memwr_M, regwrite_M, rd_M, wbsrcm,
           ALUOut_M, pc4_M, readdata_M, countdone,
    input  stall_M, valid_W, regwrite_W, rd_W, result_W, misalign_W, mem_timeout
  );

  modport slave (
    input  valid_M, memrd_M, memwr_M, regwrite_M, rd_M, wbsrcm,
           ALUOut_M, pc4_M, readdata_M, countdone,
    output stall_M, valid_W, regwrite_W, rd_W, result_W, misalign_W, mem_timeout
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: waits on memory completion, formats load data,
// flags misaligned accesses and aborts accesses that exceed TIMEOUT cycles.
module mem_wb_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic     clk,
  input  logic     rst,
  mem_wb_if.slave  bus
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        memop;
  logic        timing_out;
  logic        stall;
  logic        retire;
  logic        mis;
  logic [31:0] res;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign memop      = bus.valid_M & (bus.memrd_M | bus.memwr_M);
  // Last WAIT cycle without completion: release the pipe but drop the instruction.
  assign timing_out = (state == WAIT) & ~bus.countdone & (cnt == CNT_LAST);
  assign retire     = bus.valid_M & ~stall & ~timing_out;
  assign bus.stall_M = stall;

  // Stall request; forced low during reset so an aborted access never holds the pipe.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      if (state == IDLE) stall = memop & ~bus.countdone;
      else               stall = ~bus.countdone & (cnt != CNT_LAST);
    end
  end

  // Writeback data select and load extraction.
  always_comb begin
    byte_sel = bus.readdata_M[8*bus.ALUOut_M[1:0] +: 8];
    half_sel = bus.ALUOut_M[1] ? bus.readdata_M[31:16] : bus.readdata_M[15:0];
    case (bus.wbsrcm)
      3'b001:  res = bus.readdata_M;
      3'b010:  res = {{24{byte_sel[7]}}, byte_sel};
      3'b011:  res = {24'h0, byte_sel};
      3'b100:  res = {{16{half_sel[15]}}, half_sel};
      3'b101:  res = {16'h0, half_sel};
      3'b110:  res = bus.pc4_M;
      default: res = bus.ALUOut_M;
    endcase
  end

  // Alignment check: word loads/stores need addr[1:0]==0, halfword loads addr[0]==0.
  always_comb begin
    mis = 1'b0;
    if (bus.memrd_M && bus.wbsrcm == 3'b001 && bus.ALUOut_M[1:0] != 2'b00) mis = 1'b1;
    if (bus.memrd_M && (bus.wbsrcm == 3'b100 || bus.wbsrcm == 3'b101) && bus.ALUOut_M[0]) mis = 1'b1;
    if (bus.memwr_M && bus.wbsrcm == 3'b001 && bus.ALUOut_M[1:0] != 2'b00) mis = 1'b1;
  end

  // Access-wait FSM, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 8'd0;
      bus.mem_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (memop && !bus.countdone) begin
          state <= WAIT;
          cnt   <= 8'd0;
        end
        WAIT: begin
          if (bus.countdone) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state           <= IDLE;
            bus.mem_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // WB registers: load on retire, otherwise register a bubble holding rd/result.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.valid_W    <= 1'b0;
      bus.regwrite_W <= 1'b0;
      bus.rd_W       <= 5'd0;
      bus.result_W   <= 32'd0;
      bus.misalign_W <= 1'b0;
    end else if (retire) begin
      bus.valid_W    <= 1'b1;
      bus.regwrite_W <= bus.regwrite_M & ~bus.memwr_M & ~mis;
      bus.rd_W       <= bus.rd_M;
      bus.result_W   <= res;
      bus.misalign_W <= mis;
    end else begin
      bus.valid_W    <= 1'b0;
      bus.regwrite_W <= 1'b0;
      bus.misalign_W <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver pushes expected retirements,
// monitor pops and compares whenever valid_W is presented.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_if bus ();
  mem_wb_stage #(.TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        rw;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   done  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rdop, input logic wrop, input logic rw,
                       input logic [4:0] rd, input logic [2:0] src, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [31:0] rdata, input logic cd);
    bus.valid_M = v;   bus.memrd_M = rdop; bus.memwr_M = wrop; bus.regwrite_M = rw;
    bus.rd_M = rd;     bus.wbsrcm = src;   bus.ALUOut_M = alu; bus.pc4_M = pc4;
    bus.readdata_M = rdata; bus.countdone = cd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 0);
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] res, input logic rw, input logic mis);
    exp_t e;
    e.rd = rd; e.res = res; e.rw = rw; e.mis = mis;
    q.push_back(e);
  endtask

  // One cycle: check stall_M mid-cycle, then advance past the edge.
  task automatic step(input string nm, input logic exp_stall);
    @(negedge clk);
    chk(nm, bus.stall_M, exp_stall);
    @(posedge clk); #1;
  endtask

  // Monitor: compare each retirement against the queue head; bubbles must not write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!done) begin
        if (bus.valid_W === 1'b1) begin
          if (q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_retire: got rd=%0d result=%h expected no retire", bus.rd_W, bus.result_W);
          end else begin
            e = q.pop_front();
            chk("rd_W", 32'(bus.rd_W), 32'(e.rd));
            chk("result_W", bus.result_W, e.res);
            chk("regwrite_W", 32'(bus.regwrite_W), 32'(e.rw));
            chk("misalign_W", 32'(bus.misalign_W), 32'(e.mis));
          end
        end else begin
          chk("bubble_regwrite", 32'(bus.regwrite_W), 32'd0);
          chk("bubble_misalign", 32'(bus.misalign_W), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a pending memop: stall must stay low, all WB state clear.
    rst = 1'b1;
    drive(1, 1, 0, 1, 5'd1, 3'b001, 32'h100, 32'd0, 32'd0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(bus.stall_M), 32'd0);
    chk("rst_valid_W", 32'(bus.valid_W), 32'd0);
    chk("rst_regwrite_W", 32'(bus.regwrite_W), 32'd0);
    chk("rst_rd_W", 32'(bus.rd_W), 32'd0);
    chk("rst_result_W", bus.result_W, 32'd0);
    chk("rst_misalign_W", 32'(bus.misalign_W), 32'd0);
    chk("rst_timeout", 32'(bus.mem_timeout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    step("idle_stall", 0);

    // ALU op, countdone ignored for non-memop
    drive(1, 0, 0, 1, 5'd3, 3'b000, 32'h12345678, 32'd0, 32'd0, 1);
    push(5'd3, 32'h12345678, 1, 0); step("alu_stall", 0);
    // LW hit
    drive(1, 1, 0, 1, 5'd5, 3'b001, 32'h100, 32'd0, 32'hDEADBEEF, 1);
    push(5'd5, 32'hDEADBEEF, 1, 0); step("lw_hit_stall", 0);
    // LB miss, byte 3, four stall cycles
    drive(1, 1, 0, 1, 5'd6, 3'b010, 32'h103, 32'd0, 32'h80123456, 0);
    for (int i = 0; i < 4; i++) step("lb_miss_stall", 1);
    bus.countdone = 1'b1;
    push(5'd6, 32'hFFFFFF80, 1, 0); step("lb_done_stall", 0);
    // LHU upper half
    drive(1, 1, 0, 1, 5'd7, 3'b101, 32'h202, 32'd0, 32'hABCD1234, 1);
    push(5'd7, 32'h0000ABCD, 1, 0); step("lhu_stall", 0);
    // LH misaligned
    drive(1, 1, 0, 1, 5'd8, 3'b100, 32'h203, 32'd0, 32'hABCD1234, 1);
    push(5'd8, 32'hFFFFABCD, 0, 1); step("lh_mis_stall", 0);
    // LBU byte 1, LB byte 0 positive, LH sign-extended low half
    drive(1, 1, 0, 1, 5'd11, 3'b011, 32'h101, 32'd0, 32'h1122B344, 1);
    push(5'd11, 32'h000000B3, 1, 0); step("lbu_stall", 0);
    drive(1, 1, 0, 1, 5'd12, 3'b010, 32'h100, 32'd0, 32'h0000007F, 1);
    push(5'd12, 32'h0000007F, 1, 0); step("lb_pos_stall", 0);
    drive(1, 1, 0, 1, 5'd13, 3'b100, 32'h200, 32'd0, 32'h12348001, 1);
    push(5'd13, 32'hFFFF8001, 1, 0); step("lh_stall", 0);
    // Aligned store, misaligned store, misaligned LW
    drive(1, 0, 1, 1, 5'd9, 3'b001, 32'h104, 32'd0, 32'h5555AAAA, 1);
    push(5'd9, 32'h5555AAAA, 0, 0); step("sw_stall", 0);
    drive(1, 0, 1, 1, 5'd9, 3'b001, 32'h106, 32'd0, 32'h5555AAAA, 1);
    push(5'd9, 32'h5555AAAA, 0, 1); step("sw_mis_stall", 0);
    drive(1, 1, 0, 1, 5'd14, 3'b001, 32'h101, 32'd0, 32'h01020304, 1);
    push(5'd14, 32'h01020304, 0, 1); step("lw_mis_stall", 0);
    // PC+4 select and 111 aliasing ALU
    drive(1, 0, 0, 1, 5'd10, 3'b110, 32'h999, 32'h44, 32'd0, 0);
    push(5'd10, 32'h44, 1, 0); step("pc4_stall", 0);
    drive(1, 0, 0, 1, 5'd15, 3'b111, 32'hCAFE, 32'h44, 32'd0, 0);
    push(5'd15, 32'hCAFE, 1, 0); step("src7_stall", 0);
    // Bubble with stray countdone: rd/result held
    drive(0, 0, 0, 0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1);
    step("bubble_stall", 0);
    @(negedge clk);
    chk("held_rd_W", 32'(bus.rd_W), 32'd15);
    chk("held_result_W", bus.result_W, 32'hCAFE);
    @(posedge clk); #1;

    // Timeout: 8 stall cycles, then bubble and sticky flag
    drive(1, 1, 0, 1, 5'd16, 3'b001, 32'h300, 32'd0, 32'h77777777, 0);
    for (int i = 0; i < 8; i++) step("to_stall", 1);
    @(negedge clk);
    chk("to_release_stall", 32'(bus.stall_M), 32'd0);
    chk("to_pre_flag", 32'(bus.mem_timeout), 32'd0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("to_flag", 32'(bus.mem_timeout), 32'd1);
    chk("to_bubble", 32'(bus.valid_W), 32'd0);
    @(posedge clk); #1;
    drive(1, 0, 0, 1, 5'd17, 3'b000, 32'h1, 32'd0, 32'd0, 0);
    push(5'd17, 32'h1, 1, 0); step("post_to_stall", 0);
    idle();
    step("idle2_stall", 0);
    chk("to_sticky", 32'(bus.mem_timeout), 32'd1);

    // Reset on the 2nd WAIT cycle aborts the access
    drive(1, 1, 0, 1, 5'd18, 3'b001, 32'h400, 32'd0, 32'h0, 0);
    step("rw_idle_stall", 1);
    step("rw_wait1_stall", 1);
    rst = 1'b1;
    step("rw_rst_stall", 0);
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("rw_state_idle", 32'(bus.stall_M), 32'd0);
    chk("rw_valid_W", 32'(bus.valid_W), 32'd0);
    chk("rw_timeout", 32'(bus.mem_timeout), 32'd0);
    chk("rw_result_W", bus.result_W, 32'd0);
    @(posedge clk); #1;
    drive(1, 1, 0, 1, 5'd19, 3'b001, 32'h500, 32'd0, 32'h13579BDF, 1);
    push(5'd19, 32'h13579BDF, 1, 0); step("post_rst_stall", 0);
    idle();
    repeat (3) step("drain_stall", 0);
    done = 1;
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
